arc4_ctrl: RTL and testbench
============================

// Module: arc4_ctrl
// PURPOSE
//  Top-level sequencer for the ARC4 datapath. On one start request it runs init -> ksa -> prga in order,
//  using the en/rdy handshake of each engine, and gives each engine sole ownership of the shared S memory port.
//  Sits between the board top and the three engines. Replaces hand-wired enables in the task tops.
// PARAMETERS
//  KEY_W           24    key width, latched on start and presented to ksa
//  ADDR_W          8     S memory address width
//  DATA_W          8     S memory data width
//  TIMEOUT_CYCLES  8192  per-phase watchdog limit (used only with ARC4_CTRL_TIMEOUT_EN)
// PORTS
//  clk          in   1       system clock (CLOCK_50 at top)
//  rst_n        in   1       synchronous active-low reset (KEY[3] at top)
//  en           in   1       start request; accepted only when rdy=1
//  rdy          out  1       1 = idle, ready to accept en
//  done         out  1       one-cycle pulse when prga finishes
//  err          out  1       sticky watchdog error (0 when macro is absent)
//  key          in   KEY_W   key, sampled on the accepting edge
//  key_q        out  KEY_W   latched key, to ksa
//  init_en/ksa_en/prga_en          out 1       one-cycle start pulses to the engines
//  init_rdy/ksa_rdy/prga_rdy       in  1       engine ready flags
//  {init,ksa,prga}_addr            in  ADDR_W  engine S addresses
//  {init,ksa,prga}_wrdata          in  DATA_W  engine S write data
//  {init,ksa,prga}_wren            in  1       engine S write enables
//  s_addr       out  ADDR_W  muxed S memory address (s_rddata is routed directly to all engines)
//  s_wrdata     out  DATA_W  muxed S write data
//  s_wren       out  1       muxed S write enable
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, rdy=1, done=0, err=0, key_q=0, all *_en=0, owner=NONE.
//   Reset mid-run aborts at once and returns to IDLE. The engines share rst_n.
//  FSM: IDLE -> INIT_GO -> INIT_WAIT -> KSA_GO -> KSA_WAIT -> PRGA_GO -> PRGA_WAIT -> DONE -> IDLE; ERR (from *_WAIT).
//  IDLE: rdy=1. On en=1, latch key_q<=key and go to INIT_GO. If en=1 while rdy=0, ignore it (no queueing).
//  X_GO: x_en = (state==X_GO && x_rdy), combinational. When x_rdy=1, pulse x_en for exactly one cycle and go to X_WAIT.
//   Otherwise hold in X_GO.
//  X_WAIT: a seen_busy flag clears on entry and sets when x_rdy=0. Advance on x_rdy=1 && seen_busy.
//   This makes the cycle right after the en pulse, where rdy may still be 1, harmless.
//  DONE: done=1 for one cycle, then IDLE. Start latency: en accepted at edge k -> init_en high in cycle k+1 if init_rdy.
//  Ownership: owner=INIT in INIT_GO/WAIT, KSA in KSA_GO/WAIT, PRGA in PRGA_GO/WAIT, otherwise NONE.
//   s_addr/s_wrdata/s_wren follow the owner combinationally, with zero added latency.
//   Owner NONE drives addr=0, wrdata=0, wren=0. Writes from non-owners are dropped.
//  rdy is 0 in every state except IDLE. done and rdy are never high in the same cycle.
// CONFIGURATION
//  ARC4_CTRL_TIMEOUT_EN defined:
//   - a cycle counter clears on entry to each *_GO state; its width is $clog2(TIMEOUT_CYCLES+1).
//   - at count==TIMEOUT_CYCLES in any *_GO/*_WAIT state, go to ERR, set err=1 and owner=NONE.
//   - ERR is held until rst_n.
//  Not defined: no counter, no ERR state, err tied to 0, and the FSM waits indefinitely.
// STRUCTURE
//  arc4_pkg: state_t enum, owner_t enum {OWN_NONE, OWN_INIT, OWN_KSA, OWN_PRGA}, ARC4_ADDR_W/ARC4_DATA_W/ARC4_KEY_W.
//  Sub-module arc4_mem_mux: purely combinational owner_t-selected 3:1 mux of {addr, wrdata, wren}.
//  arc4_ctrl holds the FSM, key latch, seen_busy flag and optional watchdog.
// TESTING
//  Engine models in the bench: rdy drops 1 cycle after en, with busy lengths init=256, ksa=768, prga=1500.
//  1 Reset, then en=1 with key=24'h00033C
//    -> rdy=0 next cycle, key_q=24'h00033C, init_en high exactly 1 cycle, s_addr tracks init_addr.
//  2 Full run -> en pulses in order init, ksa, prga, each only after the previous rdy rises;
//    one done pulse; rdy=1 the cycle after done.
//  3 During KSA_WAIT, drive init_wren=1 and prga_wren=1 -> s_wren equals ksa_wren only.
//  4 en=1 held through a run -> exactly one run; a second run starts only once rdy=1.
//  5 rst_n=0 for 1 cycle during KSA_WAIT -> next cycle state IDLE, rdy=1, all en=0, s_wren=0.
//  6 (TIMEOUT_EN, TIMEOUT_CYCLES=64) ksa model never re-raises rdy -> err=1 after 64 cycles in KSA phase,
//    s_wren=0, stuck until reset.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and default widths for the ARC4 sequencer, its bus interface and the S-memory mux.
package arc4_pkg;

  localparam int ARC4_ADDR_W = 8;
  localparam int ARC4_DATA_W = 8;
  localparam int ARC4_KEY_W  = 24;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_GO,
    S_INIT_WAIT,
    S_KSA_GO,
    S_KSA_WAIT,
    S_PRGA_GO,
    S_PRGA_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_KSA,
    OWN_PRGA
  } owner_t;

  // The engine that owns the S port is a pure function of the sequencer state.
  function automatic owner_t owner_of(input state_t s);
    case (s)
      S_INIT_GO, S_INIT_WAIT: owner_of = OWN_INIT;
      S_KSA_GO,  S_KSA_WAIT:  owner_of = OWN_KSA;
      S_PRGA_GO, S_PRGA_WAIT: owner_of = OWN_PRGA;
      default:                owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arc4_ctrl_if.sv
// Bundle of the start handshake, engine handshakes and S-memory buses around arc4_ctrl.
interface arc4_ctrl_if
  import arc4_pkg::*;
#(
  parameter int KEY_W  = ARC4_KEY_W,
  parameter int ADDR_W = ARC4_ADDR_W,
  parameter int DATA_W = ARC4_DATA_W
);

  logic              en;
  logic              rdy;
  logic              done;
  logic              err;
  logic [KEY_W-1:0]  key;
  logic [KEY_W-1:0]  key_q;

  logic              init_en;
  logic              ksa_en;
  logic              prga_en;
  logic              init_rdy;
  logic              ksa_rdy;
  logic              prga_rdy;

  logic [ADDR_W-1:0] init_addr;
  logic [ADDR_W-1:0] ksa_addr;
  logic [ADDR_W-1:0] prga_addr;
  logic [DATA_W-1:0] init_wrdata;
  logic [DATA_W-1:0] ksa_wrdata;
  logic [DATA_W-1:0] prga_wrdata;
  logic              init_wren;
  logic              ksa_wren;
  logic              prga_wren;

  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wrdata;
  logic              s_wren;

  modport master (
    input  en, key,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output rdy, done, err, key_q,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren
  );

  modport slave (
    output en, key,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  rdy, done, err, key_q,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren
  );

endinterface

// File: rtl/arc4_mem_mux.sv
// Combinational owner-selected 3:1 mux onto the shared S memory port; no owner drives all zeros.
module arc4_mem_mux
  import arc4_pkg::*;
#(
  parameter int ADDR_W = ARC4_ADDR_W,
  parameter int DATA_W = ARC4_DATA_W
) (
  input  owner_t            owner,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (owner)
      OWN_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      OWN_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      OWN_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_ctrl.sv
// ARC4 sequencer: one start runs init -> ksa -> prga with exclusive S-port ownership per phase.
// Optional per-phase watchdog enabled by defining ARC4_CTRL_TIMEOUT_EN.
module arc4_ctrl
  import arc4_pkg::*;
#(
  parameter int KEY_W          = ARC4_KEY_W,
  parameter int ADDR_W         = ARC4_ADDR_W,
  parameter int DATA_W         = ARC4_DATA_W,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  arc4_ctrl_if.master bus
);

  state_t state;
  state_t state_nx;
  owner_t owner;
  logic   seen_busy;
  logic   phase_rdy;
  logic   in_go;
  logic   in_wait;

  assign in_go   = (state inside {S_INIT_GO, S_KSA_GO, S_PRGA_GO});
  assign in_wait = (state inside {S_INIT_WAIT, S_KSA_WAIT, S_PRGA_WAIT});
  assign owner   = owner_of(state);

  always_comb begin
    phase_rdy = 1'b0;
    case (owner)
      OWN_INIT: phase_rdy = bus.init_rdy;
      OWN_KSA:  phase_rdy = bus.ksa_rdy;
      OWN_PRGA: phase_rdy = bus.prga_rdy;
      default:  phase_rdy = 1'b0;
    endcase
  end

`ifdef ARC4_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             timeout;
  logic             entering_go;

  assign timeout     = (in_go || in_wait) && (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign entering_go = (state_nx != state) && (state_nx inside {S_INIT_GO, S_KSA_GO, S_PRGA_GO});

  always_ff @(posedge clk) begin
    if (!rst_n)            cnt <= '0;
    else if (entering_go)  cnt <= '0;
    else if (in_go || in_wait) cnt <= cnt + 1'b1;
  end
`endif

  // A phase only completes after its engine has been seen busy, so a ready flag
  // that lingers for a cycle after the en pulse cannot end the phase early.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (bus.en) state_nx = S_INIT_GO;
      S_INIT_GO:   if (bus.init_rdy) state_nx = S_INIT_WAIT;
      S_INIT_WAIT: if (bus.init_rdy && seen_busy) state_nx = S_KSA_GO;
      S_KSA_GO:    if (bus.ksa_rdy) state_nx = S_KSA_WAIT;
      S_KSA_WAIT:  if (bus.ksa_rdy && seen_busy) state_nx = S_PRGA_GO;
      S_PRGA_GO:   if (bus.prga_rdy) state_nx = S_PRGA_WAIT;
      S_PRGA_WAIT: if (bus.prga_rdy && seen_busy) state_nx = S_DONE;
      S_DONE:      state_nx = S_IDLE;
      S_ERR:       state_nx = S_ERR;
      default:     state_nx = S_IDLE;
    endcase
`ifdef ARC4_CTRL_TIMEOUT_EN
    if (timeout) state_nx = S_ERR;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      seen_busy <= 1'b0;
      bus.key_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.en) bus.key_q <= bus.key;
      if (in_go)                       seen_busy <= 1'b0;
      else if (in_wait && !phase_rdy)  seen_busy <= 1'b1;
    end
  end

  assign bus.rdy     = (state == S_IDLE);
  assign bus.done    = (state == S_DONE);
  assign bus.init_en = (state == S_INIT_GO) && bus.init_rdy;
  assign bus.ksa_en  = (state == S_KSA_GO)  && bus.ksa_rdy;
  assign bus.prga_en = (state == S_PRGA_GO) && bus.prga_rdy;

`ifdef ARC4_CTRL_TIMEOUT_EN
  assign bus.err = (state == S_ERR);
`else
  assign bus.err = 1'b0;
`endif

  arc4_mem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .owner       (owner),
    .init_addr   (bus.init_addr),
    .init_wrdata (bus.init_wrdata),
    .init_wren   (bus.init_wren),
    .ksa_addr    (bus.ksa_addr),
    .ksa_wrdata  (bus.ksa_wrdata),
    .ksa_wren    (bus.ksa_wren),
    .prga_addr   (bus.prga_addr),
    .prga_wrdata (bus.prga_wrdata),
    .prga_wren   (bus.prga_wren),
    .s_addr      (bus.s_addr),
    .s_wrdata    (bus.s_wrdata),
    .s_wren      (bus.s_wren)
  );

endmodule

// File: tb/tb_arc4_ctrl.sv
// Bench for arc4_ctrl: engine models plus a timeline reference computed from engine busy lengths.
module tb_arc4_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arc4_ctrl_if #(.KEY_W(24), .ADDR_W(8), .DATA_W(8)) bus ();

  arc4_ctrl #(
    .KEY_W          (24),
    .ADDR_W         (8),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   e_len [3];
  int   e_cnt [3];
  logic [2:0] e_rdy;
  logic [2:0] e_pend;
  logic [2:0] en_vec;
  bit   ksa_hang = 1'b0;

  assign en_vec       = {bus.prga_en, bus.ksa_en, bus.init_en};
  assign bus.init_rdy = e_rdy[0];
  assign bus.ksa_rdy  = e_rdy[1];
  assign bus.prga_rdy = e_rdy[2];

  // Engine models: ready drops one cycle after en and stays low for e_len cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        e_rdy[i]  <= 1'b1;
        e_pend[i] <= 1'b0;
        e_cnt[i]  <= 0;
      end else begin
        if (e_pend[i]) begin
          e_pend[i] <= 1'b0;
          e_rdy[i]  <= 1'b0;
          e_cnt[i]  <= e_len[i];
        end else if (!e_rdy[i]) begin
          if (e_cnt[i] == 1 && !(i == 1 && ksa_hang)) e_rdy[i] <= 1'b1;
          e_cnt[i] <= e_cnt[i] - 1;
        end
        if (en_vec[i]) e_pend[i] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_engines();
    bus.init_addr   = 8'($urandom);
    bus.ksa_addr    = 8'($urandom);
    bus.prga_addr   = 8'($urandom);
    bus.init_wrdata = 8'($urandom);
    bus.ksa_wrdata  = 8'($urandom);
    bus.prga_wrdata = 8'($urandom);
    bus.init_wren   = 1'($urandom_range(0, 1));
    bus.ksa_wren    = 1'($urandom_range(0, 1));
    bus.prga_wren   = 1'($urandom_range(0, 1));
  endtask

  // One start request from idle. Reference timeline, in cycles after the accepting edge:
  // each engine's en fires at the phase start, and a phase lasts busy length + 3 cycles.
  task automatic run(input logic [23:0] key_v, input bit hold, input int abort_t);
    int b, c, d, last, own;
    logic [7:0] ea, ed;
    logic       ew;
    b = e_len[0] + 3;
    c = b + e_len[1] + 3;
    d = c + e_len[2] + 3;
    last = (abort_t >= 0) ? abort_t : d + 1;
    bus.en  = 1'b1;
    bus.key = key_v;
    @(posedge clk);
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      bus.en  = hold;
      bus.key = 24'($urandom);
      drive_engines();
      own = (t < b) ? 1 : (t < c) ? 2 : (t < d) ? 3 : 0;
      if (own == 2) begin
        bus.init_wren = 1'b1;
        bus.prga_wren = 1'b1;
      end
      #1;
      case (own)
        1: begin ea = bus.init_addr; ed = bus.init_wrdata; ew = bus.init_wren; end
        2: begin ea = bus.ksa_addr;  ed = bus.ksa_wrdata;  ew = bus.ksa_wren;  end
        3: begin ea = bus.prga_addr; ed = bus.prga_wrdata; ew = bus.prga_wren; end
        default: begin ea = 8'h00; ed = 8'h00; ew = 1'b0; end
      endcase
      check("rdy",      64'(bus.rdy),     64'(t == d + 1));
      check("done",     64'(bus.done),    64'(t == d));
      check("init_en",  64'(bus.init_en), 64'(t == 0));
      check("ksa_en",   64'(bus.ksa_en),  64'(t == b));
      check("prga_en",  64'(bus.prga_en), 64'(t == c));
      check("err",      64'(bus.err),     64'(0));
      check("key_q",    64'(bus.key_q),   64'(key_v));
      check("s_addr",   64'(bus.s_addr),  64'(ea));
      check("s_wrdata", 64'(bus.s_wrdata), 64'(ed));
      check("s_wren",   64'(bus.s_wren),  64'(ew));
    end
    if (abort_t >= 0) begin
      bus.init_wren = 1'b1;
      bus.ksa_wren  = 1'b1;
      bus.prga_wren = 1'b1;
      bus.en        = 1'b0;
      rst_n         = 1'b0;
      @(posedge clk);
      #1;
      check("abort_rdy",    64'(bus.rdy),    64'(1));
      check("abort_done",   64'(bus.done),   64'(0));
      check("abort_en",     64'(en_vec),     64'(0));
      check("abort_s_wren", 64'(bus.s_wren), 64'(0));
      check("abort_key_q",  64'(bus.key_q),  64'(0));
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    int b;
`ifdef ARC4_CTRL_TIMEOUT_EN
    e_len[0] = 30; e_len[1] = 40; e_len[2] = 50;
`else
    e_len[0] = 256; e_len[1] = 768; e_len[2] = 1500;
`endif
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.key = 24'h0;
    drive_engines();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_rdy",   64'(bus.rdy),    64'(1));
    check("rst_done",  64'(bus.done),   64'(0));
    check("rst_err",   64'(bus.err),    64'(0));
    check("rst_key_q", 64'(bus.key_q),  64'(0));
    check("rst_en",    64'(en_vec),     64'(0));
    check("rst_addr",  64'(bus.s_addr), 64'(0));
    check("rst_wren",  64'(bus.s_wren), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run(24'h00033C, 1'b0, -1);
    run(24'($urandom), 1'b1, -1);
    run(24'($urandom), 1'b0, -1);
    run(24'($urandom), 1'b0, e_len[0] + 3 + 100 < e_len[0] + e_len[1] + 6 ?
                               e_len[0] + 3 + 20 : e_len[0] + 4);
    run(24'($urandom), 1'b0, -1);

`ifdef ARC4_CTRL_TIMEOUT_EN
    ksa_hang = 1'b1;
    b = e_len[0] + 3;
    bus.en  = 1'b1;
    bus.key = 24'h00ABCD;
    @(posedge clk);
    for (int t = 0; t <= b + 80; t++) begin
      @(negedge clk);
      bus.en = 1'b0;
      drive_engines();
      bus.ksa_wren = 1'b1;
      #1;
      check("to_err", 64'(bus.err), 64'(t >= b + 65));
      check("to_rdy", 64'(bus.rdy), 64'(0));
      if (t >= b + 65) begin
        check("to_s_wren", 64'(bus.s_wren), 64'(0));
        check("to_s_addr", 64'(bus.s_addr), 64'(0));
        check("to_en",     64'(en_vec),     64'(0));
      end
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("to_rst_err", 64'(bus.err), 64'(0));
    check("to_rst_rdy", 64'(bus.rdy), 64'(1));
    @(negedge clk);
    rst_n    = 1'b1;
    ksa_hang = 1'b0;
    @(negedge clk);
    run(24'($urandom), 1'b0, -1);
`else
    b = 0;
    check("no_err", 64'(bus.err), 64'(b));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
